// File: rtl/param_code_detonator_pkg.sv
// param_code_detonator_pkg
// Shared types and helpers for the parametrised code detonator.
//   state_e        : FSM state encoding (also driven out on state_o)
//   bcd_t          : decoded keypad value plus a valid flag
//   BLANK_DIGIT    : display code shown while the digits are masked
//   onehot_to_bcd  : 10-key one-hot to BCD; valid only when exactly one bit is set
package param_code_detonator_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSetup  = 3'd1,
        StEntry  = 3'd2,
        StArmed  = 3'd3,
        StCount  = 3'd4,
        StDone   = 3'd5,
        StLocked = 3'd6
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] digit;
    } bcd_t;

    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    function automatic bcd_t onehot_to_bcd(input logic [9:0] a);
        bcd_t        r;
        int unsigned n;
        r.valid = 1'b0;
        r.digit = 4'd0;
        n       = 0;
        for (int i = 0; i < 10; i++) begin
            if (a[i]) begin
                n       = n + 1;
                r.digit = 4'(i);
            end
        end
        r.valid = (n == 1);
        return r;
    endfunction

endpackage

// File: rtl/param_code_detonator_key_capture.sv
// code_key_capture
// Registers the keypad and flags a new digit when the keypad is exactly one-hot
// and differs from its registered value (a fresh press, or a key change without
// release). All-zero and multi-hot values never produce a digit.
//   clk, rst     : clock, synchronous active-high reset
//   a            : raw 10-key one-hot keypad
//   digit_valid  : a new digit is present this cycle
//   digit        : BCD value of the key (meaningful while digit_valid)
module code_key_capture
    import param_code_detonator_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] a,
    output logic       digit_valid,
    output logic [3:0] digit
);

    logic [9:0] a_q;
    bcd_t       dec;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= 10'd0;
        end else begin
            a_q <= a;
        end
    end

    always_comb begin
        dec         = onehot_to_bcd(a);
        digit_valid = dec.valid && (a != a_q);
        digit       = dec.digit;
    end

endmodule

// File: rtl/param_code_detonator.sv
// param_code_detonator
// Keypad code lock with run-time programmable code, retry limit with timed
// lockout, abort, and a fire countdown ending in a latched detonation state.
// Optional build macro MASK_DISP_EN: blanks m_disp during SETUP/ENTRY and
// returns it to 0 on entering IDLE.
//   clk, rst   : clock, synchronous active-high reset (top priority)
//   A          : one-hot keypad, bit k = digit k
//   setup      : enter code programming (from IDLE)
//   ready      : start code entry (from IDLE)
//   sure       : confirm entered digits
//   fire       : fire request (ARMED only)
//   wait_t     : abort / disarm
//   m_disp     : last accepted digit (BCD)
//   digit_cnt  : digits entered, saturating at CODE_LEN
//   lt/bt/rt   : armed / detonated / locked-out LEDs
//   lb         : one-cycle wrong-code pulse
//   state_o    : current FSM state encoding
module param_code_detonator
    import param_code_detonator_pkg::*;
#(
    parameter int unsigned           CODE_LEN     = 4,
    parameter int unsigned           MAX_TRIES    = 3,
    parameter int unsigned           LOCK_CYCLES  = 16,
    parameter int unsigned           FIRE_CYCLES  = 8,
    parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE = 16'h2580
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [9:0]                    A,
    input  logic                          setup,
    input  logic                          ready,
    input  logic                          sure,
    input  logic                          fire,
    input  logic                          wait_t,
    output logic [3:0]                    m_disp,
    output logic [$clog2(CODE_LEN+1)-1:0] digit_cnt,
    output logic                          lt,
    output logic                          bt,
    output logic                          rt,
    output logic                          lb,
    output logic [2:0]                    state_o
);

    localparam int unsigned BW   = 4 * CODE_LEN;
    localparam int unsigned CW   = $clog2(CODE_LEN + 1);
    localparam int unsigned TRW  = $clog2(MAX_TRIES + 1);
    localparam int unsigned TMAX = (FIRE_CYCLES > LOCK_CYCLES) ? FIRE_CYCLES : LOCK_CYCLES;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [CW-1:0]  CntFull   = CW'(CODE_LEN);
    localparam logic [TRW-1:0] TriesMax  = TRW'(MAX_TRIES);
    localparam logic [TW-1:0]  FireLoad  = TW'(FIRE_CYCLES - 1);
    localparam logic [TW-1:0]  LockLoad  = TW'(LOCK_CYCLES - 1);

    state_e         state_q, state_d;
    logic [BW-1:0]  code_q, buf_q;
    logic [CW-1:0]  cnt_q;
    logic [TRW-1:0] tries_q;
    logic [TW-1:0]  timer_q, timer_d;
    logic [3:0]     m_disp_q;
    logic           lb_q;

    logic           digit_valid;
    logic [3:0]     digit;
    logic           cnt_full, key_ok, code_match;

    // FSM strobes towards the datapath
    logic           clr_entry, key_take, code_we, miss, tries_clr;

    code_key_capture u_key_capture (
        .clk         (clk),
        .rst         (rst),
        .a           (A),
        .digit_valid (digit_valid),
        .digit       (digit)
    );

    assign cnt_full   = (cnt_q == CntFull);
    assign key_ok     = digit_valid && !cnt_full;
    assign code_match = (buf_q == code_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next-state logic. wait_t is tested before sure/fire/keys, and a key in the
    // same cycle as sure is never taken so sure always sees the prior buffer.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        clr_entry = 1'b0;
        key_take  = 1'b0;
        code_we   = 1'b0;
        miss      = 1'b0;
        tries_clr = 1'b0;
        case (state_q)
            StIdle: begin
                if (setup) begin
                    state_d   = StSetup;
                    clr_entry = 1'b1;
                end else if (ready) begin
                    state_d   = StEntry;
                    clr_entry = 1'b1;
                end
            end
            StSetup: begin
                if (wait_t) begin
                    state_d = StIdle;
                end else if (sure) begin
                    if (cnt_full) begin
                        code_we = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    key_take = key_ok;
                end
            end
            StEntry: begin
                if (wait_t) begin
                    state_d = StIdle;
                end else if (sure) begin
                    if (cnt_full) begin
                        if (code_match) begin
                            state_d   = StArmed;
                            tries_clr = 1'b1;
                        end else begin
                            miss      = 1'b1;
                            clr_entry = 1'b1;
                            if (tries_q + TRW'(1) == TriesMax) begin
                                state_d = StLocked;
                                timer_d = LockLoad;
                            end
                        end
                    end
                end else begin
                    key_take = key_ok;
                end
            end
            StArmed: begin
                if (wait_t) begin
                    state_d = StIdle;
                end else if (fire) begin
                    state_d = StCount;
                    timer_d = FireLoad;
                end
            end
            StCount: begin
                if (wait_t) begin
                    state_d = StIdle;
                end else if (timer_q == '0) begin
                    state_d = StDone;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            StDone: begin
                state_d = StDone;
            end
            StLocked: begin
                if (timer_q == '0) begin
                    state_d   = StIdle;
                    tries_clr = 1'b1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q   <= DEFAULT_CODE;
            buf_q    <= '0;
            cnt_q    <= '0;
            tries_q  <= '0;
            m_disp_q <= 4'd0;
            lb_q     <= 1'b0;
        end else begin
            lb_q <= miss;
            if (code_we) begin
                code_q <= buf_q;
            end
            if (clr_entry) begin
                buf_q <= '0;
                cnt_q <= '0;
            end else if (key_take) begin
                buf_q <= (buf_q << 4) | BW'(digit);
                cnt_q <= cnt_q + CW'(1);
            end
            if (tries_clr) begin
                tries_q <= '0;
            end else if (miss) begin
                tries_q <= tries_q + TRW'(1);
            end
            if (key_take) begin
                m_disp_q <= digit;
`ifdef MASK_DISP_EN
            end else if (state_d == StIdle && state_q != StIdle) begin
                m_disp_q <= 4'd0;
`endif
            end
        end
    end

    // Outputs
    always_comb begin
        lt        = (state_q == StArmed) || (state_q == StCount);
        bt        = (state_q == StDone);
        rt        = (state_q == StLocked);
        lb        = lb_q;
        digit_cnt = cnt_q;
        state_o   = state_q;
`ifdef MASK_DISP_EN
        m_disp    = ((state_q == StSetup) || (state_q == StEntry)) ? BLANK_DIGIT : m_disp_q;
`else
        m_disp    = m_disp_q;
`endif
    end

endmodule

// File: tb/tb_param_code_detonator.sv
module tb_param_code_detonator;

    localparam logic [2:0] S_IDLE = 3'd0, S_SETUP = 3'd1, S_ENTRY = 3'd2, S_ARMED = 3'd3;
    localparam logic [2:0] S_COUNT = 3'd4, S_DONE = 3'd5, S_LOCKED = 3'd6;

    logic       clk = 1'b0;
    logic       rst, setup, ready, sure, fire, wait_t;
    logic [9:0] A;
    logic [3:0] m_disp;
    logic [2:0] digit_cnt;
    logic       lt, bt, rt, lb;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    param_code_detonator dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .setup     (setup),
        .ready     (ready),
        .sure      (sure),
        .fire      (fire),
        .wait_t    (wait_t),
        .m_disp    (m_disp),
        .digit_cnt (digit_cnt),
        .lt        (lt),
        .bt        (bt),
        .rt        (rt),
        .lb        (lb),
        .state_o   (state_o)
    );

    typedef struct packed {
        logic       rst;
        logic [9:0] a;
        logic       setup, ready, sure, fire, wait_t;
    } vin_t;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] disp;
        logic [2:0] cnt;
        logic       lt, bt, rt, lb;
    } vout_t;

    typedef struct packed {
        vin_t  i;
        vout_t o;
    } vec_t;

    vout_t sb[$];
    vec_t  tbl[$];
    int    n_vec = 0;
    int    n_bad = 0;

    function automatic logic [9:0] key(input int d);
        logic [9:0] one;
        one = 10'd1;
        return one << d;
    endfunction

    function automatic vin_t vin(input logic r, input logic [9:0] a, input logic su,
                                 input logic rd, input logic sr, input logic fi, input logic wt);
        return {r, a, su, rd, sr, fi, wt};
    endfunction

    function automatic vout_t vo(input logic [2:0] st, input logic [3:0] d, input logic [2:0] c,
                                 input logic l, input logic b, input logic r, input logic p);
        return {st, d, c, l, b, r, p};
    endfunction

    // Drive one cycle, queue its expected result, compare once the edge has passed.
    task automatic step(input string tag, input vin_t vi, input vout_t ve);
        vout_t got, want;
        rst    = vi.rst;
        A      = vi.a;
        setup  = vi.setup;
        ready  = vi.ready;
        sure   = vi.sure;
        fire   = vi.fire;
        wait_t = vi.wait_t;
        sb.push_back(ve);
        @(posedge clk);
        #1;
        want = sb.pop_front();
        got  = {state_o, m_disp, digit_cnt, lt, bt, rt, lb};
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got st=%0d disp=%h cnt=%0d lt=%b bt=%b rt=%b lb=%b, want st=%0d disp=%h cnt=%0d lt=%b bt=%b rt=%b lb=%b",
                     tag, got.st, got.disp, got.cnt, got.lt, got.bt, got.rt, got.lb,
                     want.st, want.disp, want.cnt, want.lt, want.bt, want.rt, want.lb);
        end
    endtask

    task automatic idle(input string tag, input vout_t ve);
        step(tag, vin(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), ve);
    endtask

    // Press and release each of four BCD digits, MSD first.
    task automatic enter4(input string tag, input logic [15:0] code, input logic [2:0] st);
        logic [3:0] d;
        for (int i = 0; i < 4; i++) begin
            d = code[15-4*i -: 4];
            step(tag, vin(1'b0, key(int'(d)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                 vo(st, d, 3'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0));
            idle(tag, vo(st, d, 3'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    initial begin
        // Default-code arm and fire sequence as a vector table
        tbl.push_back({vin(1, 0, 0, 0, 0, 0, 0), vo(S_IDLE, 0, 0, 0, 0, 0, 0)});
        tbl.push_back({vin(0, 0, 0, 0, 0, 0, 0), vo(S_IDLE, 0, 0, 0, 0, 0, 0)});
        tbl.push_back({vin(0, 0, 0, 1, 0, 0, 0), vo(S_ENTRY, 0, 0, 0, 0, 0, 0)});
        tbl.push_back({vin(0, key(2), 0, 0, 0, 0, 0), vo(S_ENTRY, 2, 1, 0, 0, 0, 0)});
        tbl.push_back({vin(0, 0, 0, 0, 0, 0, 0), vo(S_ENTRY, 2, 1, 0, 0, 0, 0)});
        tbl.push_back({vin(0, key(5), 0, 0, 0, 0, 0), vo(S_ENTRY, 5, 2, 0, 0, 0, 0)});
        tbl.push_back({vin(0, 0, 0, 0, 0, 0, 0), vo(S_ENTRY, 5, 2, 0, 0, 0, 0)});
        tbl.push_back({vin(0, key(8), 0, 0, 0, 0, 0), vo(S_ENTRY, 8, 3, 0, 0, 0, 0)});
        tbl.push_back({vin(0, 0, 0, 0, 0, 0, 0), vo(S_ENTRY, 8, 3, 0, 0, 0, 0)});
        tbl.push_back({vin(0, key(0), 0, 0, 0, 0, 0), vo(S_ENTRY, 0, 4, 0, 0, 0, 0)});
        tbl.push_back({vin(0, 0, 0, 0, 0, 0, 0), vo(S_ENTRY, 0, 4, 0, 0, 0, 0)});
        tbl.push_back({vin(0, 0, 0, 0, 1, 0, 0), vo(S_ARMED, 0, 4, 1, 0, 0, 0)});
        tbl.push_back({vin(0, 0, 0, 0, 0, 0, 0), vo(S_ARMED, 0, 4, 1, 0, 0, 0)});
        tbl.push_back({vin(0, 0, 0, 0, 0, 1, 0), vo(S_COUNT, 0, 4, 1, 0, 0, 0)});
        for (int i = 0; i < 7; i++) begin
            tbl.push_back({vin(0, 0, 0, 0, 0, 0, 0), vo(S_COUNT, 0, 4, 1, 0, 0, 0)});
        end
        tbl.push_back({vin(0, 0, 0, 0, 0, 0, 0), vo(S_DONE, 0, 4, 0, 1, 0, 0)});
        tbl.push_back({vin(0, key(3), 1, 1, 1, 1, 1), vo(S_DONE, 0, 4, 0, 1, 0, 0)});
        tbl.push_back({vin(0, 0, 0, 0, 0, 0, 0), vo(S_DONE, 0, 4, 0, 1, 0, 0)});

        foreach (tbl[k]) begin
            step($sformatf("arm_tbl[%0d]", k), tbl[k].i, tbl[k].o);
        end

        step("rst_done", vin(1, 0, 0, 0, 0, 0, 0), vo(S_IDLE, 0, 0, 0, 0, 0, 0));

        // Three wrong attempts lead to a 16-cycle lockout
        step("ready_wrong", vin(0, 0, 0, 1, 0, 0, 0), vo(S_ENTRY, 0, 0, 0, 0, 0, 0));
        for (int t = 0; t < 3; t++) begin
            enter4("wrong_keys", 16'h2581, S_ENTRY);
            if (t < 2) begin
                step("wrong_sure", vin(0, 0, 0, 0, 1, 0, 0), vo(S_ENTRY, 1, 0, 0, 0, 0, 1));
                idle("lb_pulse_end", vo(S_ENTRY, 1, 0, 0, 0, 0, 0));
            end else begin
                step("lock_enter", vin(0, 0, 0, 0, 1, 0, 0), vo(S_LOCKED, 1, 0, 0, 0, 1, 1));
            end
        end
        for (int i = 0; i < 15; i++) begin
            if (i == 5) begin
                step("locked_ignore", vin(0, key(7), 1, 1, 1, 1, 1), vo(S_LOCKED, 1, 0, 0, 0, 1, 0));
            end else begin
                idle("locked", vo(S_LOCKED, 1, 0, 0, 0, 1, 0));
            end
        end
        idle("lock_exit", vo(S_IDLE, 1, 0, 0, 0, 0, 0));

        // Reprogram to 1357; old code now fails, new one arms
        step("setup", vin(0, 0, 1, 0, 0, 0, 0), vo(S_SETUP, 1, 0, 0, 0, 0, 0));
        enter4("prog_keys", 16'h1357, S_SETUP);
        step("prog_sure", vin(0, 0, 0, 0, 1, 0, 0), vo(S_IDLE, 7, 4, 0, 0, 0, 0));
        step("ready_old", vin(0, 0, 0, 1, 0, 0, 0), vo(S_ENTRY, 7, 0, 0, 0, 0, 0));
        enter4("old_keys", 16'h2580, S_ENTRY);
        step("old_sure", vin(0, 0, 0, 0, 1, 0, 0), vo(S_ENTRY, 0, 0, 0, 0, 0, 1));
        enter4("new_keys", 16'h1357, S_ENTRY);
        step("new_sure", vin(0, 0, 0, 0, 1, 0, 0), vo(S_ARMED, 7, 4, 1, 0, 0, 0));

        // Abort three cycles after fire
        step("fire", vin(0, 0, 0, 0, 0, 1, 0), vo(S_COUNT, 7, 4, 1, 0, 0, 0));
        idle("count1", vo(S_COUNT, 7, 4, 1, 0, 0, 0));
        idle("count2", vo(S_COUNT, 7, 4, 1, 0, 0, 0));
        step("abort", vin(0, 0, 0, 0, 0, 0, 1), vo(S_IDLE, 7, 4, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++) begin
            idle("no_boom", vo(S_IDLE, 7, 4, 0, 0, 0, 0));
        end

        // Short entry: sure ignored
        step("ready_short", vin(0, 0, 0, 1, 0, 0, 0), vo(S_ENTRY, 7, 0, 0, 0, 0, 0));
        step("short_2", vin(0, key(2), 0, 0, 0, 0, 0), vo(S_ENTRY, 2, 1, 0, 0, 0, 0));
        idle("short_rel", vo(S_ENTRY, 2, 1, 0, 0, 0, 0));
        step("short_5", vin(0, key(5), 0, 0, 0, 0, 0), vo(S_ENTRY, 5, 2, 0, 0, 0, 0));
        idle("short_rel", vo(S_ENTRY, 5, 2, 0, 0, 0, 0));
        step("short_sure", vin(0, 0, 0, 0, 1, 0, 0), vo(S_ENTRY, 5, 2, 0, 0, 0, 0));

        // Key edge handling
        step("abort_entry", vin(0, 0, 0, 0, 0, 0, 1), vo(S_IDLE, 5, 2, 0, 0, 0, 0));
        step("ready_keys", vin(0, 0, 0, 1, 0, 0, 0), vo(S_ENTRY, 5, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            step("hold_5", vin(0, key(5), 0, 0, 0, 0, 0), vo(S_ENTRY, 5, 1, 0, 0, 0, 0));
        end
        idle("hold_rel", vo(S_ENTRY, 5, 1, 0, 0, 0, 0));
        step("multi_hot", vin(0, 10'b0000000110, 0, 0, 0, 0, 0), vo(S_ENTRY, 5, 1, 0, 0, 0, 0));
        idle("multi_rel", vo(S_ENTRY, 5, 1, 0, 0, 0, 0));
        step("chg_2", vin(0, key(2), 0, 0, 0, 0, 0), vo(S_ENTRY, 2, 2, 0, 0, 0, 0));
        step("chg_5", vin(0, key(5), 0, 0, 0, 0, 0), vo(S_ENTRY, 5, 3, 0, 0, 0, 0));
        idle("chg_rel", vo(S_ENTRY, 5, 3, 0, 0, 0, 0));
        step("sure_key_short", vin(0, key(9), 0, 0, 1, 0, 0), vo(S_ENTRY, 5, 3, 0, 0, 0, 0));
        idle("sk_rel", vo(S_ENTRY, 5, 3, 0, 0, 0, 0));
        step("key_9", vin(0, key(9), 0, 0, 0, 0, 0), vo(S_ENTRY, 9, 4, 0, 0, 0, 0));
        idle("k9_rel", vo(S_ENTRY, 9, 4, 0, 0, 0, 0));
        step("saturate", vin(0, key(3), 0, 0, 0, 0, 0), vo(S_ENTRY, 9, 4, 0, 0, 0, 0));
        idle("sat_rel", vo(S_ENTRY, 9, 4, 0, 0, 0, 0));
        step("sure_key_full", vin(0, key(7), 0, 0, 1, 0, 0), vo(S_ENTRY, 9, 0, 0, 0, 0, 1));
        idle("skf_rel", vo(S_ENTRY, 9, 0, 0, 0, 0, 0));

        // Reset mid-countdown restores the default code
        step("abort_entry2", vin(0, 0, 0, 0, 0, 0, 1), vo(S_IDLE, 9, 0, 0, 0, 0, 0));
        step("ready_rst", vin(0, 0, 0, 1, 0, 0, 0), vo(S_ENTRY, 9, 0, 0, 0, 0, 0));
        enter4("rst_keys", 16'h1357, S_ENTRY);
        step("rst_arm", vin(0, 0, 0, 0, 1, 0, 0), vo(S_ARMED, 7, 4, 1, 0, 0, 0));
        step("rst_fire", vin(0, 0, 0, 0, 0, 1, 0), vo(S_COUNT, 7, 4, 1, 0, 0, 0));
        idle("rst_count", vo(S_COUNT, 7, 4, 1, 0, 0, 0));
        idle("rst_count", vo(S_COUNT, 7, 4, 1, 0, 0, 0));
        step("rst_in_count", vin(1, 0, 0, 0, 0, 0, 0), vo(S_IDLE, 0, 0, 0, 0, 0, 0));
        idle("post_rst", vo(S_IDLE, 0, 0, 0, 0, 0, 0));
        step("ready_dflt", vin(0, 0, 0, 1, 0, 0, 0), vo(S_ENTRY, 0, 0, 0, 0, 0, 0));
        enter4("dflt_keys", 16'h2580, S_ENTRY);
        step("dflt_arm", vin(0, 0, 0, 0, 1, 0, 0), vo(S_ARMED, 0, 4, 1, 0, 0, 0));
        step("armed_abort", vin(0, 0, 0, 0, 0, 1, 1), vo(S_IDLE, 0, 4, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
